tetris_game_ctrl: RTL and testbench
===================================

# tetris_game_ctrl

Game sequencer for the 4-wide × 8-deep Tetris board. It owns the settled-board register and the active-piece mask, and it steps through piece spawn, gravity, left/right moves, lock, and row scan/clear. Each row clear is one controlled shift step, so clears are serialised. It sits between player/timer inputs and the display/readout logic, and it replaces single-shot clear-and-redraw with a cycle-accurate schedule.

## Interface
Parameters:
- `LINES_W`, default 8: width of the cleared-lines counter. The counter saturates.

Ports:
- `clka`, input, 1: system clock. All state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: start or restart the game. Honoured only in IDLE or OVER.
- `drop_tick`, input, 1: single-cycle gravity pulse.
- `move_l`, input, 1: request to shift the active piece one column toward column 0.
- `move_r`, input, 1: request to shift the active piece one column toward column 3.
- `next_piece`, input, 2: shape to spawn. 00 = single, 01 = horizontal pair, 10 = square, 11 = L.
- `board_out`, output, 32: settled board OR active mask.
- `spawn_ack`, output, 1: one-cycle pulse when `next_piece` is sampled.
- `piece_active`, output, 1: high while in FALL.
- `clearing`, output, 1: high in SCAN or SHIFT.
- `game_over`, output, 1: high in OVER.
- `lines`, output, `LINES_W`: rows cleared since the last start.

## Operation
Board geometry:
- Row k is `bits[4k+3:4k]`. Row 0 is the top and row 7 is the bottom.
- Column c is bit `4k+c`.
- Moving down is mask << 4. Moving left is mask >> 1. Moving right is mask << 1.

Spawn shapes (bit indices):
- 00 → {1}
- 01 → {1,2}
- 10 → {1,2,5,6}
- 11 → {1,5,6}

States:
- **IDLE**
  - On `start`: clear board, mask and `lines`, then go to SPAWN.
- **SPAWN** (1 cycle)
  - Sample `next_piece` and pulse `spawn_ack`.
  - If the shape overlaps the board: go to OVER, and the mask stays 0.
  - Otherwise: mask ← shape, go to FALL.
- **FALL** (at most one action per cycle; priority `drop_tick` > move)
  - `drop_tick` when the piece can move down (no bit in row 7 and no overlap after the shift): mask ← mask << 4.
  - `drop_tick` when the piece cannot move down: go to LOCK.
  - `move_l` without `move_r`: shift left unless any bit is in column 0 or the shifted mask overlaps the board. If blocked, hold.
  - `move_r` without `move_l`: shift right unless any bit is in column 3 or the shifted mask overlaps the board. If blocked, hold.
  - `move_l` and `move_r` together: ignored.
- **LOCK** (1 cycle)
  - board ← board | mask, mask ← 0, row_idx ← 7, go to SCAN.
- **SCAN**
  - If row row_idx is 4'b1111: go to SHIFT.
  - Else if row_idx == 0: go to SPAWN.
  - Else: row_idx ← row_idx − 1.
- **SHIFT** (1 cycle)
  - Rows 0..row_idx−1 move down one row. Row 0 ← 0.
  - `lines` ← `lines` + 1, saturating at all-ones.
  - Go back to SCAN with the same row_idx, so stacked full rows are re-checked.
- **OVER**
  - The board holds and inputs are ignored.
  - On `start`: same action as `start` in IDLE.

Constants:
- `start` outside IDLE/OVER is ignored.
- Move and tick inputs outside FALL are ignored and are not queued.

## Timing
- Reset values:
  - `board_out` = 0, `lines` = 0.
  - `spawn_ack`, `piece_active`, `clearing`, `game_over` = 0.
  - State = IDLE, row_idx = 7.
- Assertion of `rst_n` at any point aborts the current operation immediately and reloads the reset values. This includes mid-SHIFT, where no partial shift is left behind.
- Outputs are registered-state decodes; `board_out` is board | mask from registers. Outputs change only after clock edges.
- Latencies:
  - `start` → `spawn_ack` high on the next cycle.
  - Spawn to `piece_active`: 1 cycle.
- Lock with no full rows: LOCK (1) + SCAN (8) + SPAWN (1) = 10 cycles from the blocked tick to the next `piece_active`.
- Each cleared row adds 1 SHIFT cycle plus 1 re-scan cycle.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-FALL.
  - Required: all outputs 0 and state IDLE.
  - Then `start`: `spawn_ack` pulses 1 cycle later.
- **Gravity and lock.** `start`, `next_piece`=00, 7 `drop_tick`s.
  - Required: `board_out`=32'h2000_0000.
  - 8th tick: after 10 cycles, `board_out`=32'h2000_0002, `lines`=0.
- **Moves.** `next_piece`=00.
  - `move_l` ×2 → mask bit 0 (the second move is blocked).
  - `move_l` and `move_r` together → no change.
  - `drop_tick` with `move_r` in the same cycle → mask bit 4 only.
- **Double clear.**
  - Square, `move_l`, drop to the bottom.
  - Square, `move_r`, drop to the bottom.
  - Required: two SHIFT cycles, `lines`=2, settled board 0, next spawn visible.
- **Game over.** Nine `next_piece`=00 pieces, each dropped straight down.
  - After the 8th lock, `board_out`=32'h2222_2222.
  - 9th spawn: `game_over`=1 and the board holds.
  - `start` → board 0, `lines` 0, `spawn_ack`.
- **Saturation.** With `LINES_W`=2, clear 5 rows → `lines` stays at 3.

Source files
------------

// File: rtl/tetris_game_ctrl.sv
// Game sequencer for a 4-wide x 8-deep Tetris board: spawn, gravity, moves,
// lock and a serialised row scan/clear, one controlled step per clock.
module tetris_game_ctrl #(
    parameter int LINES_W = 8
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic               start,
    input  logic               drop_tick,
    input  logic               move_l,
    input  logic               move_r,
    input  logic [1:0]         next_piece,
    output logic [31:0]        board_out,
    output logic               spawn_ack,
    output logic               piece_active,
    output logic               clearing,
    output logic               game_over,
    output logic [LINES_W-1:0] lines
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_SCAN,
        S_SHIFT,
        S_OVER
    } state_t;

    localparam logic [31:0] COL0 = 32'h1111_1111;
    localparam logic [31:0] COL3 = 32'h8888_8888;

    state_t             state, state_next;
    logic [31:0]        board, board_next;
    logic [31:0]        mask, mask_next;
    logic [2:0]         row_idx, row_idx_next;
    logic [LINES_W-1:0] lines_q, lines_next;

    logic [31:0] shape;
    logic [31:0] down_mask, left_mask, right_mask;
    logic [31:0] shifted_board;
    logic        can_down, can_left, can_right, row_full;

    always_comb begin
        shape = 32'h0;
        case (next_piece)
            2'b00: shape = 32'h0000_0002;
            2'b01: shape = 32'h0000_0006;
            2'b10: shape = 32'h0000_0066;
            2'b11: shape = 32'h0000_0062;
            default: shape = 32'h0;
        endcase
    end

    assign down_mask  = mask << 4;
    assign left_mask  = mask >> 1;
    assign right_mask = mask << 1;
    assign can_down   = (mask[31:28] == 4'h0) && ((down_mask & board) == 32'h0);
    assign can_left   = ((mask & COL0) == 32'h0) && ((left_mask & board) == 32'h0);
    assign can_right  = ((mask & COL3) == 32'h0) && ((right_mask & board) == 32'h0);
    assign row_full   = (board[{row_idx, 2'b00} +: 4] == 4'hF);

    // Rows above the cleared row drop by one; rows below it are untouched.
    always_comb begin
        shifted_board       = board;
        shifted_board[3:0]  = 4'h0;
        for (int k = 1; k < 8; k++) begin
            if (3'(k) <= row_idx) begin
                shifted_board[4*k +: 4] = board[4*(k-1) +: 4];
            end
        end
    end

    always_comb begin
        state_next   = state;
        board_next   = board;
        mask_next    = mask;
        row_idx_next = row_idx;
        lines_next   = lines_q;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    board_next = 32'h0;
                    mask_next  = 32'h0;
                    lines_next = '0;
                    state_next = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if ((shape & board) != 32'h0) begin
                    state_next = S_OVER;
                end else begin
                    mask_next  = shape;
                    state_next = S_FALL;
                end
            end
            S_FALL: begin
                if (drop_tick) begin
                    if (can_down) begin
                        mask_next = down_mask;
                    end else begin
                        state_next = S_LOCK;
                    end
                end else if (move_l && !move_r) begin
                    if (can_left) begin
                        mask_next = left_mask;
                    end
                end else if (move_r && !move_l) begin
                    if (can_right) begin
                        mask_next = right_mask;
                    end
                end
            end
            S_LOCK: begin
                board_next   = board | mask;
                mask_next    = 32'h0;
                row_idx_next = 3'd7;
                state_next   = S_SCAN;
            end
            S_SCAN: begin
                if (row_full) begin
                    state_next = S_SHIFT;
                end else if (row_idx == 3'd0) begin
                    state_next = S_SPAWN;
                end else begin
                    row_idx_next = row_idx - 3'd1;
                end
            end
            S_SHIFT: begin
                // Same row_idx on return so a stacked full row is re-checked.
                board_next = shifted_board;
                lines_next = (lines_q == '1) ? lines_q : lines_q + 1'b1;
                state_next = S_SCAN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            board   <= 32'h0;
            mask    <= 32'h0;
            row_idx <= 3'd7;
            lines_q <= '0;
        end else begin
            state   <= state_next;
            board   <= board_next;
            mask    <= mask_next;
            row_idx <= row_idx_next;
            lines_q <= lines_next;
        end
    end

    assign board_out    = board | mask;
    assign spawn_ack    = (state == S_SPAWN);
    assign piece_active = (state == S_FALL);
    assign clearing     = (state == S_SCAN) || (state == S_SHIFT);
    assign game_over    = (state == S_OVER);
    assign lines        = lines_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl; a second instance with LINES_W=2
// runs the same stimulus to exercise counter saturation.
module tb_tetris_game_ctrl;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        drop_tick = 1'b0;
    logic        move_l = 1'b0;
    logic        move_r = 1'b0;
    logic [1:0]  next_piece = 2'b00;

    logic [31:0] board_out, board_s;
    logic        spawn_ack, piece_active, clearing, game_over;
    logic        spawn_ack_s, piece_active_s, clearing_s, game_over_s;
    logic [7:0]  lines;
    logic [1:0]  lines_s;
    logic [3:0]  flags, flags_s;

    int          vectors = 0;
    int          miscompares = 0;
    int          n;
    logic [31:0] exp_b;
    logic [1:0]  np_tab [3] = '{2'b10, 2'b10, 2'b00};
    logic [31:0] brd_tab [3] = '{32'h66, 32'h66, 32'h2};
    logic [7:0]  lines_tab [3] = '{8'd2, 8'd4, 8'd6};
    logic [1:0]  sat_tab [3] = '{2'd2, 2'd3, 2'd3};

    assign flags   = {spawn_ack, piece_active, clearing, game_over};
    assign flags_s = {spawn_ack_s, piece_active_s, clearing_s, game_over_s};

    tetris_game_ctrl #(.LINES_W(8)) dut (
        .clka(clka), .rst_n(rst_n), .start(start), .drop_tick(drop_tick),
        .move_l(move_l), .move_r(move_r), .next_piece(next_piece),
        .board_out(board_out), .spawn_ack(spawn_ack), .piece_active(piece_active),
        .clearing(clearing), .game_over(game_over), .lines(lines)
    );

    tetris_game_ctrl #(.LINES_W(2)) dut_s (
        .clka(clka), .rst_n(rst_n), .start(start), .drop_tick(drop_tick),
        .move_l(move_l), .move_r(move_r), .next_piece(next_piece),
        .board_out(board_s), .spawn_ack(spawn_ack_s), .piece_active(piece_active_s),
        .clearing(clearing_s), .game_over(game_over_s), .lines(lines_s)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic drop(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            drop_tick = 1'b1;
            tick();
            drop_tick = 1'b0;
        end
    endtask

    // Blocked tick, then count cycles until the next piece or game over (bounded).
    task automatic lock_piece(output int cycles);
        drop_tick = 1'b1;
        tick();
        drop_tick = 1'b0;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(piece_active || game_over) && cycles < 40);
    endtask

    task automatic pulse_move(input logic l, input logic r);
        move_l = l;
        move_r = r;
        tick();
        move_l = 1'b0;
        move_r = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_board", board_out, 32'h0);
        check("rst_lines", 32'(lines), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        rst_n = 1'b1;

        // start latency, then reset mid-FALL
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ack", 32'(flags), 32'h8);
        tick();
        check("spawn_fall", 32'(flags), 32'h4);
        check("spawn_board", board_out, 32'h2);
        drop(1);
        check("first_drop", board_out, 32'h20);
        rst_n = 1'b0;
        #1;
        check("midfall_rst_board", board_out, 32'h0);
        check("midfall_rst_flags", 32'(flags), 32'h0);
        rst_n = 1'b1;
        drop(1);
        check("idle_ignores_tick", board_out, 32'h0);
        check("idle_flags", 32'(flags), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ack", 32'(flags), 32'h8);
        tick();

        // gravity and lock
        drop(7);
        check("gravity_bottom", board_out, 32'h2000_0000);
        lock_piece(n);
        check("lock_latency", 32'(n), 32'd10);
        check("lock_board", board_out, 32'h2000_0002);
        check("lock_lines", 32'(lines), 32'h0);

        // moves
        pulse_move(1'b1, 1'b0);
        check("move_l", board_out, 32'h2000_0001);
        pulse_move(1'b1, 1'b0);
        check("move_l_blocked", board_out, 32'h2000_0001);
        pulse_move(1'b1, 1'b1);
        check("move_both", board_out, 32'h2000_0001);
        drop_tick = 1'b1;
        move_r    = 1'b1;
        tick();
        drop_tick = 1'b0;
        move_r    = 1'b0;
        check("drop_beats_move", board_out, 32'h2000_0010);
        for (int i = 0; i < 4; i++) pulse_move(1'b0, 1'b1);
        check("move_r_blocked", board_out, 32'h2000_0080);
        drop(6);
        lock_piece(n);
        check("lock2_latency", 32'(n), 32'd10);
        check("lock2_board", board_out, 32'hA000_0002);

        // double clears, three rounds
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_piece = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("square_spawn", board_out, 32'h66);
        for (int r = 0; r < 3; r++) begin
            pulse_move(1'b1, 1'b0);
            check("sq_left", board_out, 32'h33);
            drop(6);
            check("sq_left_bottom", board_out, 32'h3300_0000);
            lock_piece(n);
            check("sq_left_lock", 32'(n), 32'd10);
            check("sq_left_board", board_out, 32'h3300_0066);
            pulse_move(1'b0, 1'b1);
            check("sq_right", board_out, 32'h3300_00CC);
            drop(6);
            check("sq_full_rows", board_out, 32'hFF00_0000);
            next_piece = np_tab[r];
            lock_piece(n);
            check("dbl_clear_latency", 32'(n), 32'd14);
            check("dbl_clear_lines", 32'(lines), 32'(lines_tab[r]));
            check("dbl_clear_sat", 32'(lines_s), 32'(sat_tab[r]));
            check("dbl_clear_board", board_out, brd_tab[r]);
            check("dbl_clear_board_s", board_s, brd_tab[r]);
        end

        // game over: single pieces stacked down column 1
        for (int k = 1; k <= 8; k++) begin
            drop(8 - k);
            lock_piece(n);
            check("stack_latency", 32'(n), 32'd10);
            exp_b = 32'h0;
            for (int j = 0; j < k; j++) exp_b = exp_b | (32'h2 << (4 * (7 - j)));
            if (k < 8) begin
                exp_b = exp_b | 32'h2;
                check("stack_flags", 32'(flags), 32'h4);
            end
            check("stack_board", board_out, exp_b);
        end
        check("over_flags", 32'(flags), 32'h1);
        check("over_board", board_out, 32'h2222_2222);
        drop_tick = 1'b1;
        move_l    = 1'b1;
        tick();
        tick();
        drop_tick = 1'b0;
        move_l    = 1'b0;
        check("over_hold_board", board_out, 32'h2222_2222);
        check("over_hold_flags", 32'(flags), 32'h1);
        check("over_hold_lines", 32'(lines), 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("over_restart_ack", 32'(flags), 32'h8);
        check("over_restart_board", board_out, 32'h0);
        check("over_restart_lines", 32'(lines), 32'h0);
        check("over_restart_sat", 32'(lines_s), 32'h0);
        tick();
        check("over_respawn", board_out, 32'h2);
        check("over_respawn_s", 32'(flags_s), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
